// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces start/stop and clear buttons, runs the
// IDLE/RUN/PAUSE/DONE state machine and produces counter/scan enable strobes.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned SCAN_DIV   = 131072,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       max_reached,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       scan_en,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEB_CYCLES);

  localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] ScanLast = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DebLast  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Bit 0 carries the start/stop button, bit 1 the clear button.
  logic [1:0]         meta_q, sync_q;
  logic [1:0]         level_q, level_d;
  logic [1:0]         press_q, press_d;
  logic [1:0][DW-1:0] deb_q, deb_d;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          scan_en_q, scan_en_d;
  logic          running_q;

  logic ss_press, clr_press;
  assign ss_press  = press_q[0];
  assign clr_press = press_q[1];

  always_comb begin
    deb_d   = '0;
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != level_q[i]) begin
        if (deb_q[i] == DebLast) begin
          level_d[i] = sync_q[i];
          press_d[i] = sync_q[i];
        end else begin
          deb_d[i] = deb_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        tick_d = '0;
        if (clr_press) begin
          cnt_clr_d = 1'b1;
        end else if (ss_press) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (clr_press) begin
          cnt_clr_d = 1'b1;
          state_d   = StIdle;
          tick_d    = '0;
        end else if (tick_q == TickLast) begin
          tick_d = '0;
          // Reaching the maximum takes precedence over a coincident pause.
          if (max_reached) begin
            state_d = StDone;
          end else begin
            cnt_en_d = 1'b1;
            if (ss_press) state_d = StPause;
          end
        end else begin
          tick_d = tick_q + 1'b1;
          if (ss_press) state_d = StPause;
        end
      end
      StPause: begin
        if (clr_press) begin
          cnt_clr_d = 1'b1;
          state_d   = StIdle;
          tick_d    = '0;
        end else if (ss_press) begin
          state_d = StRun;
        end
      end
      StDone: begin
        tick_d = '0;
        if (clr_press) begin
          cnt_clr_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign scan_d    = (scan_q == ScanLast) ? '0 : scan_q + 1'b1;
  assign scan_en_d = (scan_q == ScanLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q    <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      deb_q     <= '0;
      state_q   <= StIdle;
      tick_q    <= '0;
      scan_q    <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      scan_en_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      meta_q    <= {btn_clr, btn_ss};
      sync_q    <= meta_q;
      level_q   <= level_d;
      press_q   <= press_d;
      deb_q     <= deb_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
      scan_q    <= scan_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      scan_en_q <= scan_en_d;
      running_q <= (state_d == StRun);
    end
  end

  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;
  assign scan_en = scan_en_q;
  assign running = running_q;
  assign state   = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch datapath. Debounces the start/stop and clear buttons and runs the IDLE/RUN/PAUSE/DONE state machine. Generates single-cycle enable strobes for the time counter and display scan, so downstream logic stays on `clk` and needs no derived clocks. Sits between the board buttons and the BCD time counter / display multiplexer.

Parameters:
- TICK_DIV, 100000: `clk` cycles per `cnt_en` strobe (1 ms at 100 MHz); must be >= 2.
- SCAN_DIV, 131072: `clk` cycles per `scan_en` strobe; must be >= 2.
- DEB_CYCLES, 1000000: consecutive stable cycles before a button level is accepted; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_ss  in  1  raw start/stop button, asynchronous, active-high.
- btn_clr  in  1  raw clear button, asynchronous, active-high.
- max_reached  in  1  from time counter: count is at its maximum value.
- cnt_en  out  1  one-cycle increment strobe to the time counter.
- cnt_clr  out  1  one-cycle clear strobe to the time counter.
- scan_en  out  1  one-cycle display digit-advance strobe.
- running  out  1  high while state == RUN.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; cnt_en, cnt_clr, scan_en, running = 0.
  - Both prescalers = 0; synchronizers and debounced levels = 0.
  - Takes effect immediately, including mid-interval or mid-debounce.
- Button path, per button:
  - 2-FF synchronizer, then debounce counter. The counter increments while the synchronized level differs from the debounced level and clears otherwise.
  - At DEB_CYCLES the debounced level flips and the counter clears.
  - press = one-cycle pulse on the debounced rising edge only; release generates nothing.
  - A glitch shorter than DEB_CYCLES produces no press.
  - A button held through reset release produces one press after debounce.
- Press latency: between DEB_CYCLES and DEB_CYCLES+4 cycles after a stable raw rise. The state change and `cnt_clr` register on the clock edge after press.
- State transitions (clear press has priority when both presses occur in the same cycle):
  - IDLE: ss -> RUN. clr -> `cnt_clr` pulse, stay IDLE.
  - RUN: clr -> `cnt_clr` pulse, go IDLE. ss -> PAUSE. Terminal tick with max_reached=1 -> DONE.
  - PAUSE: ss -> RUN. clr -> `cnt_clr` pulse, go IDLE.
  - DONE: clr -> `cnt_clr` pulse, go IDLE. ss is ignored.
- Tick prescaler, width `$clog2(TICK_DIV)`:
  - Counts 0..TICK_DIV-1 only in RUN, then wraps to 0.
  - Holds its value in PAUSE, so resume completes the partial interval.
  - Forced to 0 on `cnt_clr` and whenever state is IDLE or DONE.
- `cnt_en`:
  - High for exactly one cycle when the prescaler == TICK_DIV-1, state == RUN and max_reached == 0.
  - If max_reached == 1 at that terminal cycle, `cnt_en` stays 0 and the next state is DONE.
  - An ss press coinciding with the terminal tick: the tick is issued (`cnt_en`=1) and the next state is PAUSE.
- Scan prescaler:
  - Free-running 0..SCAN_DIV-1 in every state; `scan_en` pulses one cycle at SCAN_DIV-1.
  - Unaffected by buttons; reset only by reset.
- All outputs are registered. `cnt_en` and `cnt_clr` are never high in the same cycle.
- `running` == (state == RUN).

Test Plan:
- Bench parameters: TICK_DIV=4, SCAN_DIV=8, DEB_CYCLES=3.
- Reset then idle 40 cycles -> `scan_en` pulses every 8 cycles; `cnt_en`=0, `state`=00, all other outputs 0.
- btn_ss held high 10 cycles -> one press; `state`=01 within 3..7 cycles of the raw rise; `cnt_en` pulses every 4 cycles.
- RUN 6 cycles (prescaler=2), ss press -> `state`=10, no `cnt_en`. Second ss press -> `state`=01; the first `cnt_en` arrives 2 cycles after re-entering RUN.
- btn_ss 2-cycle glitch -> no state change. btn_ss and btn_clr rising together in PAUSE -> one `cnt_clr` pulse, `state`=00.
- RUN with max_reached=1 -> at the terminal prescaler cycle `cnt_en`=0 and `state`=11. An ss press in DONE is ignored; clr -> `cnt_clr`=1 for one cycle, `state`=00.
- reset=0 asserted mid-RUN between clock edges -> outputs 0 immediately. After release, a held btn_ss yields exactly one press.
